alu_issue_stage: RTL and testbench



---
 rtl/alu_issue_pkg.sv | 97 +++++++++
 rtl/alu_issue_stage_decode.sv | 134 +++++++++++++
 rtl/alu_issue_stage.sv | 123 ++++++++++++
 tb/tb_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU decode-and-issue stage.
//   - datapath width
//   - ALUop class / sub-op encodings and the full 4-bit op codes
//   - MIPS64 opcode and R-type funct codes recognised by the decoder
//   - issue_bundle_t: the payload handed from the issue stage to EX
package alu_issue_pkg;

  localparam int WIDTH = 64;

  // ALUop[3:2] class
  localparam logic [1:0] CLS_LOGIC = 2'b00;
  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  // ALUop[1:0] sub-op, per class
  localparam logic [1:0] SUB_AND  = 2'b00;
  localparam logic [1:0] SUB_OR   = 2'b01;
  localparam logic [1:0] SUB_XOR  = 2'b10;
  localparam logic [1:0] SUB_NOR  = 2'b11;
  localparam logic [1:0] SUB_ADD  = 2'b00;
  localparam logic [1:0] SUB_ADDU = 2'b01;
  localparam logic [1:0] SUB_SUB  = 2'b10;
  localparam logic [1:0] SUB_SUBU = 2'b11;
  localparam logic [1:0] SUB_SLT  = 2'b10;
  localparam logic [1:0] SUB_SLTU = 2'b11;
  localparam logic [1:0] SUB_SLL  = 2'b00;
  localparam logic [1:0] SUB_SRL  = 2'b10;
  localparam logic [1:0] SUB_SRA  = 2'b11;

  // Full ALUop codes
  localparam logic [3:0] ALU_AND  = {CLS_LOGIC, SUB_AND};
  localparam logic [3:0] ALU_OR   = {CLS_LOGIC, SUB_OR};
  localparam logic [3:0] ALU_XOR  = {CLS_LOGIC, SUB_XOR};
  localparam logic [3:0] ALU_NOR  = {CLS_LOGIC, SUB_NOR};
  localparam logic [3:0] ALU_ADD  = {CLS_ARITH, SUB_ADD};
  localparam logic [3:0] ALU_ADDU = {CLS_ARITH, SUB_ADDU};
  localparam logic [3:0] ALU_SUB  = {CLS_ARITH, SUB_SUB};
  localparam logic [3:0] ALU_SUBU = {CLS_ARITH, SUB_SUBU};
  localparam logic [3:0] ALU_SLT  = {CLS_CMP, SUB_SLT};
  localparam logic [3:0] ALU_SLTU = {CLS_CMP, SUB_SLTU};
  localparam logic [3:0] ALU_SLL  = {CLS_SHIFT, SUB_SLL};
  localparam logic [3:0] ALU_SRL  = {CLS_SHIFT, SUB_SRL};
  localparam logic [3:0] ALU_SRA  = {CLS_SHIFT, SUB_SRA};

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_DADDI  = 6'h18;
  localparam logic [5:0] OP_DADDIU = 6'h19;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_DADD  = 6'h2C;
  localparam logic [5:0] FN_DADDU = 6'h2D;
  localparam logic [5:0] FN_DSUB  = 6'h2E;
  localparam logic [5:0] FN_DSUBU = 6'h2F;

  typedef struct packed {
    logic [3:0]       alu_op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             wen;
    logic             trap_ovf;
    logic             illegal;
  } issue_bundle_t;

  // Immediate extension helpers
  function automatic logic [WIDTH-1:0] sext16(input logic [15:0] imm);
    return {{(WIDTH-16){imm[15]}}, imm};
  endfunction

  function automatic logic [WIDTH-1:0] zext16(input logic [15:0] imm);
    return {{(WIDTH-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_op_decode: purely combinational MIPS64 decode into an issue bundle.
// Ports:
//   instr   in  32     instruction word
//   rs_val  in  WIDTH  rs register read data
//   rt_val  in  WIDTH  rt register read data
//   bundle  out        decoded ALUop, SHAMT, operands, rd, wen, trap_ovf, illegal
// Unrecognised opcodes/functs produce an all-zero bundle with illegal set,
// so the entry still flows down the pipe in order but never writes back.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output issue_bundle_t    bundle
);

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [15:0]      imm_s;
  logic [3:0]       alu_op_s;
  logic [4:0]       shamt_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [4:0]       rd_s;
  logic             trap_s;
  logic             legal_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign imm_s    = instr[15:0];

  // Field decode: op code, operand selection, destination and trap enable
  always_comb begin
    alu_op_s = 4'b0000;
    shamt_s  = 5'd0;
    a_s      = rs_val;
    b_s      = rt_val;
    rd_s     = instr[15:11];
    trap_s   = 1'b0;
    legal_s  = 1'b1;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shifts operate on rt; B carries nothing
            a_s     = rt_val;
            b_s     = {WIDTH{1'b0}};
            shamt_s = instr[10:6];
            if (funct_s == FN_SLL) begin
              alu_op_s = ALU_SLL;
            end else if (funct_s == FN_SRL) begin
              alu_op_s = ALU_SRL;
            end else begin
              alu_op_s = ALU_SRA;
            end
          end
          FN_ADD, FN_DADD: begin
            alu_op_s = ALU_ADD;
            trap_s   = 1'b1;
          end
          FN_ADDU, FN_DADDU: alu_op_s = ALU_ADDU;
          FN_SUB, FN_DSUB: begin
            alu_op_s = ALU_SUB;
            trap_s   = 1'b1;
          end
          FN_SUBU, FN_DSUBU: alu_op_s = ALU_SUBU;
          FN_AND:  alu_op_s = ALU_AND;
          FN_OR:   alu_op_s = ALU_OR;
          FN_XOR:  alu_op_s = ALU_XOR;
          FN_NOR:  alu_op_s = ALU_NOR;
          FN_SLT:  alu_op_s = ALU_SLT;
          FN_SLTU: alu_op_s = ALU_SLTU;
          default: legal_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_DADDI: begin
        alu_op_s = ALU_ADD;
        b_s      = sext16(imm_s);
        rd_s     = instr[20:16];
        trap_s   = 1'b1;
      end
      OP_ADDIU, OP_DADDIU: begin
        alu_op_s = ALU_ADDU;
        b_s      = sext16(imm_s);
        rd_s     = instr[20:16];
      end
      OP_SLTI: begin
        alu_op_s = ALU_SLT;
        b_s      = sext16(imm_s);
        rd_s     = instr[20:16];
      end
      OP_SLTIU: begin
        alu_op_s = ALU_SLTU;
        b_s      = sext16(imm_s);
        rd_s     = instr[20:16];
      end
      OP_ANDI: begin
        alu_op_s = ALU_AND;
        b_s      = zext16(imm_s);
        rd_s     = instr[20:16];
      end
      OP_ORI: begin
        alu_op_s = ALU_OR;
        b_s      = zext16(imm_s);
        rd_s     = instr[20:16];
      end
      OP_XORI: begin
        alu_op_s = ALU_XOR;
        b_s      = zext16(imm_s);
        rd_s     = instr[20:16];
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Bundle assembly: illegal entries are squashed to a harmless all-zero op
  always_comb begin
    bundle = '0;
    if (legal_s) begin
      bundle.alu_op   = alu_op_s;
      bundle.shamt    = shamt_s;
      bundle.a        = a_s;
      bundle.b        = b_s;
      bundle.rd       = rd_s;
      bundle.wen      = (rd_s != 5'd0);
      bundle.trap_ovf = trap_s;
      bundle.illegal  = 1'b0;
    end else begin
      bundle.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-and-issue stage feeding the 64-bit ALU.
// Ports:
//   p_clk, p_rst_n                 clock, async active-low reset
//   p_id_valid/p_id_ready          ID handshake (ready is a plain register)
//   p_id_instr, p_id_rs_val/rt_val instruction word and register read data
//   p_flush                        drop every held entry
//   p_ex_valid/p_ex_ready          EX handshake
//   p_ex_ALUop, p_ex_SHAMT, p_ex_A, p_ex_B, p_ex_rd, p_ex_wen,
//   p_ex_trap_ovf, p_ex_illegal    issued bundle, always from main entry M
// Storage is a main entry M plus a skid entry S. Because ready is registered,
// one extra bundle can arrive after M stalls; S absorbs it and ready drops.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic             p_clk,
  input  logic             p_rst_n,
  input  logic             p_id_valid,
  output logic             p_id_ready,
  input  logic [31:0]      p_id_instr,
  input  logic [WIDTH-1:0] p_id_rs_val,
  input  logic [WIDTH-1:0] p_id_rt_val,
  input  logic             p_flush,
  output logic             p_ex_valid,
  input  logic             p_ex_ready,
  output logic [3:0]       p_ex_ALUop,
  output logic [4:0]       p_ex_SHAMT,
  output logic [WIDTH-1:0] p_ex_A,
  output logic [WIDTH-1:0] p_ex_B,
  output logic [4:0]       p_ex_rd,
  output logic             p_ex_wen,
  output logic             p_ex_trap_ovf,
  output logic             p_ex_illegal
);

  issue_bundle_t dec_bundle_s;
  issue_bundle_t m_bundle_r, m_bundle_s;
  issue_bundle_t s_bundle_r, s_bundle_s;
  logic          m_valid_r, m_valid_s;
  logic          s_valid_r, s_valid_s;
  logic          id_ready_r, id_ready_s;
  logic          accept_s;

  alu_op_decode u_decode (
    .instr  (p_id_instr),
    .rs_val (p_id_rs_val),
    .rt_val (p_id_rt_val),
    .bundle (dec_bundle_s)
  );

  assign accept_s = p_id_valid & id_ready_r;

  // Next-state of the M/S buffer and the registered upstream ready
  always_comb begin
    m_valid_s  = m_valid_r;
    s_valid_s  = s_valid_r;
    id_ready_s = id_ready_r;
    m_bundle_s = m_bundle_r;
    s_bundle_s = s_bundle_r;
    if (p_flush) begin
      // Flush wins over drain and accept alike
      m_valid_s  = 1'b0;
      s_valid_s  = 1'b0;
      id_ready_s = 1'b1;
    end else if (s_valid_r) begin
      // Ready is low here, so no accept can happen this cycle
      if (p_ex_ready) begin
        m_bundle_s = s_bundle_r;
        m_valid_s  = 1'b1;
        s_valid_s  = 1'b0;
        id_ready_s = 1'b1;
      end else begin
        id_ready_s = 1'b0;
      end
    end else if (accept_s) begin
      if (!m_valid_r || p_ex_ready) begin
        m_bundle_s = dec_bundle_s;
        m_valid_s  = 1'b1;
        id_ready_s = 1'b1;
      end else begin
        // M stalled: park in S and stop upstream from the next edge
        s_bundle_s = dec_bundle_s;
        s_valid_s  = 1'b1;
        id_ready_s = 1'b0;
      end
    end else begin
      id_ready_s = 1'b1;
      if (m_valid_r && p_ex_ready) begin
        m_valid_s = 1'b0;
      end else begin
        m_valid_s = m_valid_r;
      end
    end
  end

  // Buffer and handshake registers
  always_ff @(posedge p_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      id_ready_r <= 1'b1;
      m_bundle_r <= '0;
      s_bundle_r <= '0;
    end else begin
      m_valid_r  <= m_valid_s;
      s_valid_r  <= s_valid_s;
      id_ready_r <= id_ready_s;
      m_bundle_r <= m_bundle_s;
      s_bundle_r <= s_bundle_s;
    end
  end

  assign p_id_ready    = id_ready_r;
  assign p_ex_valid    = m_valid_r;
  assign p_ex_ALUop    = m_bundle_r.alu_op;
  assign p_ex_SHAMT    = m_bundle_r.shamt;
  assign p_ex_A        = m_bundle_r.a;
  assign p_ex_B        = m_bundle_r.b;
  assign p_ex_rd       = m_bundle_r.rd;
  assign p_ex_wen      = m_bundle_r.wen;
  assign p_ex_trap_ovf = m_bundle_r.trap_ovf;
  assign p_ex_illegal  = m_bundle_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a table of decode vectors issued
// back-to-back, then directed stall, flush, illegal-ordering and reset cases.
module tb_alu_issue_stage;

  logic        p_clk;
  logic        p_rst_n;
  logic        p_id_valid;
  logic        p_id_ready;
  logic [31:0] p_id_instr;
  logic [63:0] p_id_rs_val;
  logic [63:0] p_id_rt_val;
  logic        p_flush;
  logic        p_ex_valid;
  logic        p_ex_ready;
  logic [3:0]  p_ex_ALUop;
  logic [4:0]  p_ex_SHAMT;
  logic [63:0] p_ex_A;
  logic [63:0] p_ex_B;
  logic [4:0]  p_ex_rd;
  logic        p_ex_wen;
  logic        p_ex_trap_ovf;
  logic        p_ex_illegal;

  int checks;
  int failures;

  alu_issue_stage dut (
    .p_clk(p_clk), .p_rst_n(p_rst_n),
    .p_id_valid(p_id_valid), .p_id_ready(p_id_ready),
    .p_id_instr(p_id_instr), .p_id_rs_val(p_id_rs_val), .p_id_rt_val(p_id_rt_val),
    .p_flush(p_flush),
    .p_ex_valid(p_ex_valid), .p_ex_ready(p_ex_ready),
    .p_ex_ALUop(p_ex_ALUop), .p_ex_SHAMT(p_ex_SHAMT),
    .p_ex_A(p_ex_A), .p_ex_B(p_ex_B), .p_ex_rd(p_ex_rd),
    .p_ex_wen(p_ex_wen), .p_ex_trap_ovf(p_ex_trap_ovf), .p_ex_illegal(p_ex_illegal)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rs;
    logic [63:0] rt;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        trap;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] rs,
                       input logic [63:0] rt);
    p_id_valid  = v;
    p_id_instr  = ins;
    p_id_rs_val = rs;
    p_id_rt_val = rt;
  endtask

  // Checks EX valid plus the operand A tag used to identify an entry
  task automatic chk_issue(input string nm, input logic [63:0] a_exp);
    chk({nm, ".valid"}, {63'd0, p_ex_valid}, 64'd1);
    chk({nm, ".A"}, p_ex_A, a_exp);
  endtask

  task automatic chk_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    chk({nm, ".valid"}, {63'd0, p_ex_valid}, 64'd1);
    chk({nm, ".ALUop"}, {60'd0, p_ex_ALUop}, {60'd0, vecs[i].op});
    chk({nm, ".SHAMT"}, {59'd0, p_ex_SHAMT}, {59'd0, vecs[i].sh});
    chk({nm, ".A"}, p_ex_A, vecs[i].a);
    chk({nm, ".B"}, p_ex_B, vecs[i].b);
    if (!vecs[i].ill) begin
      chk({nm, ".rd"}, {59'd0, p_ex_rd}, {59'd0, vecs[i].rd});
    end
    chk({nm, ".wen"}, {63'd0, p_ex_wen}, {63'd0, vecs[i].wen});
    chk({nm, ".trap"}, {63'd0, p_ex_trap_ovf}, {63'd0, vecs[i].trap});
    chk({nm, ".ill"}, {63'd0, p_ex_illegal}, {63'd0, vecs[i].ill});
  endtask

  // Fill M (I1) and S (I2) with EX stalled; leaves I3 presented on ID
  task automatic fill_ms(input logic [63:0] t1, input logic [63:0] t2, input logic [63:0] t3);
    p_ex_ready = 1'b0;
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), t1, 64'd0);
    tick();
    chk("fill.ready1", {63'd0, p_id_ready}, 64'd1);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), t2, 64'd0);
    tick();
    chk("fill.ready0", {63'd0, p_id_ready}, 64'd0);
    chk_issue("fill.M", t1);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), t3, 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    p_rst_n  = 1'b0;
    p_flush  = 1'b0;
    p_ex_ready = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 64'd0);

    //            instr                                     rs                     rt                     op       sh     a                      b                      rd     wen   trap  ill
    vecs[0]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),    64'd5,                 64'd7,                 4'b0100, 5'd0,  64'd5,                 64'd7,                 5'd3,  1'b1, 1'b1, 1'b0};
    vecs[1]  = '{itype(6'h0C, 5'd1, 5'd2, 16'h8000),      64'hFFFF_0000_1234_5678, 64'hDEAD,            4'b0000, 5'd0,  64'hFFFF_0000_1234_5678, 64'h8000,             5'd2,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{itype(6'h09, 5'd1, 5'd9, 16'hFFFF),      64'h10,                64'h0,                 4'b0101, 5'd0,  64'h10,                64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{rtype(5'd4, 5'd5, 5'd6, 5'd13, 6'h03),   64'hAAAA,              64'h8000_0000_0000_0001, 4'b1111, 5'd13, 64'h8000_0000_0000_0001, 64'd0,              5'd6,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h2E),    64'd100,               64'd1,                 4'b0110, 5'd0,  64'd100,               64'd1,                 5'd0,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{rtype(5'd1, 5'd2, 5'd31, 5'd0, 6'h2B),   64'd3,                 64'd4,                 4'b1011, 5'd0,  64'd3,                 64'd4,                 5'd31, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27),    64'hF0,                64'h0F,                4'b0011, 5'd0,  64'hF0,                64'h0F,                5'd8,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{itype(6'h0E, 5'd1, 5'd10, 16'hFFFF),     64'd1,                 64'd2,                 4'b0010, 5'd0,  64'd1,                 64'hFFFF,              5'd10, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{itype(6'h0A, 5'd1, 5'd11, 16'h8001),     64'd2,                 64'd3,                 4'b1010, 5'd0,  64'd2,                 64'hFFFF_FFFF_FFFF_8001, 5'd11, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{itype(6'h18, 5'd1, 5'd0, 16'h0010),      64'd7,                 64'd9,                 4'b0100, 5'd0,  64'd7,                 64'h10,                5'd0,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{itype(6'h3F, 5'd1, 5'd2, 16'h1234),      64'd5,                 64'd6,                 4'b0000, 5'd0,  64'd0,                 64'd0,                 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[11] = '{rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h3F),    64'd5,                 64'd6,                 4'b0000, 5'd0,  64'd0,                 64'd0,                 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[12] = '{rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h2D),   64'd11,                64'd12,                4'b0101, 5'd0,  64'd11,                64'd12,                5'd12, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{rtype(5'd0, 5'd3, 5'd5, 5'd1, 6'h00),    64'd77,                64'd1,                 4'b1100, 5'd1,  64'd1,                 64'd0,                 5'd5,  1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst.valid", {63'd0, p_ex_valid}, 64'd0);
    chk("rst.ready", {63'd0, p_id_ready}, 64'd1);
    chk("rst.A", p_ex_A, 64'd0);
    chk("rst.ALUop", {60'd0, p_ex_ALUop}, 64'd0);
    @(negedge p_clk);
    p_rst_n = 1'b1;
    tick();

    // Table: back-to-back issue at full throughput, one cycle latency
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      tick();
      chk_vec(i);
      chk("tbl.ready", {63'd0, p_id_ready}, 64'd1);
    end
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    tick();
    chk("tbl.drain", {63'd0, p_ex_valid}, 64'd0);

    // Stall with three back-to-back sends, then release: order 1,2,3 no gaps
    fill_ms(64'h11, 64'h22, 64'h33);
    tick();
    chk("stall.ready", {63'd0, p_id_ready}, 64'd0);
    chk_issue("stall.hold", 64'h11);
    chk("stall.op", {60'd0, p_ex_ALUop}, 64'd4);
    p_ex_ready = 1'b1;
    tick();
    chk_issue("rel.2", 64'h22);
    chk("rel.ready", {63'd0, p_id_ready}, 64'd1);
    tick();
    chk_issue("rel.3", 64'h33);
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    tick();
    chk("rel.empty", {63'd0, p_ex_valid}, 64'd0);

    // Flush with M and S full and ID valid
    fill_ms(64'h41, 64'h42, 64'h43);
    p_flush = 1'b1;
    tick();
    p_flush = 1'b0;
    chk("flush.valid", {63'd0, p_ex_valid}, 64'd0);
    chk("flush.ready", {63'd0, p_id_ready}, 64'd1);
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    p_ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush.stale", {63'd0, p_ex_valid}, 64'd0);
    end

    // Flush discards a same-cycle accept
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 64'h51, 64'd0);
    p_flush = 1'b1;
    tick();
    p_flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    chk("flush.acc", {63'd0, p_ex_valid}, 64'd0);

    // Illegal entry issued in order between two legal ops
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 64'hA1, 64'd0);
    tick();
    chk_issue("ill.pre", 64'hA1);
    chk("ill.pre.ill", {63'd0, p_ex_illegal}, 64'd0);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h3F), 64'hA2, 64'd0);
    tick();
    chk("ill.valid", {63'd0, p_ex_valid}, 64'd1);
    chk("ill.ill", {63'd0, p_ex_illegal}, 64'd1);
    chk("ill.wen", {63'd0, p_ex_wen}, 64'd0);
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 64'hA3, 64'd0);
    tick();
    chk_issue("ill.post", 64'hA3);
    chk("ill.post.ill", {63'd0, p_ex_illegal}, 64'd0);
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    tick();

    // Asynchronous reset mid-stall
    fill_ms(64'h61, 64'h62, 64'h63);
    #3;
    p_rst_n = 1'b0;
    #1;
    chk("arst.valid", {63'd0, p_ex_valid}, 64'd0);
    chk("arst.ready", {63'd0, p_id_ready}, 64'd1);
    chk("arst.A", p_ex_A, 64'd0);
    chk("arst.trap", {63'd0, p_ex_trap_ovf}, 64'd0);
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    @(negedge p_clk);
    p_rst_n = 1'b1;
    p_ex_ready = 1'b1;
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 64'h71, 64'd2);
    tick();
    chk_issue("arst.first", 64'h71);
    chk("arst.first.op", {60'd0, p_ex_ALUop}, 64'd6);
    drive(1'b0, 32'd0, 64'd0, 64'd0);
    tick();
    chk("arst.nostale", {63'd0, p_ex_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
